// File: rtl/tx_pkg.sv
// tx_pkg: shared state type and line-level constants for the transmit framer
package tx_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SEND} tx_state_t;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/tx_bit_timer.sv
// tx_bit_timer: clocks-per-bit counter and frame bit index with wrap/terminal flags
module tx_bit_timer #(
  parameter int CLKS_PER_BIT = 10,
  parameter int FRAME_BITS = 10,
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1,
  localparam int BW = $clog2(FRAME_BITS)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic wrap,
  output logic last
);
  logic [CW-1:0] cyc;
  logic [BW-1:0] bit_idx;
  assign wrap = cyc == CW'(CLKS_PER_BIT - 1);
  assign last = bit_idx == BW'(FRAME_BITS - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cyc <= '0;
      bit_idx <= '0;
    end else if (clr) begin
      cyc <= '0;
      bit_idx <= '0;
    end else if (en) begin
      cyc <= wrap ? '0 : cyc + 1'b1;
      if (wrap) bit_idx <= bit_idx + 1'b1;
    end
endmodule

// File: rtl/tx_frame_ctrl.sv
// tx_frame_ctrl: builds UART-style frames and strobes a downstream LSB-first shift register
module tx_frame_ctrl
  import tx_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int CLKS_PER_BIT = 10,
  parameter int PARITY_EN = 0,
  localparam int FRAME_BITS = DATA_BITS + 2 + PARITY_EN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_valid,
  input  logic [DATA_BITS-1:0]  tx_data,
  output logic                  tx_ready,
  output logic                  load_enable,
  output logic                  shift_enable,
  output logic [FRAME_BITS-1:0] parallel_in,
  output logic                  tx_busy,
  output logic                  tx_done
);
  tx_state_t state, state_nxt;
  logic wrap, last;
  logic [FRAME_BITS-1:0] frame;
  tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT), .FRAME_BITS(FRAME_BITS)) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(state == LOAD),
    .en(state == SEND),
    .wrap(wrap),
    .last(last)
  );
  assign tx_ready = state == IDLE;
  assign tx_busy = state == LOAD || state == SEND;
  assign load_enable = state == LOAD;
  assign shift_enable = state == SEND && wrap && !last;
  assign tx_done = state == SEND && wrap && last;
  always_comb begin
    frame = {FRAME_BITS{STOP_BIT}};
    frame[DATA_BITS:1] = tx_data;
    frame[0] = START_BIT;
    if (PARITY_EN != 0) frame[FRAME_BITS-2] = ^tx_data;
  end
  // unused encoding falls back to IDLE
  always_comb
    state_nxt = state == IDLE ? (tx_valid ? LOAD : IDLE) :
                state == LOAD ? SEND :
                (state == SEND && !tx_done) ? SEND : IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      parallel_in <= {FRAME_BITS{IDLE_LEVEL}};
    end else begin
      state <= state_nxt;
      if (tx_valid && tx_ready) parallel_in <= frame;
    end
endmodule
